// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment driver: sequential double-dabble BCD
// conversion into a double-buffered display register, scanned one digit at a time.
module seg_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int BIN_W     = 16,
    parameter int SCAN_DIV  = 18,
    parameter int BLINK_DIV = 24
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [BIN_W-1:0]  data,
    input  logic              load,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_in,
    input  logic [DIGITS-1:0] blink_en,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        a_to_g,
    output logic [DIGITS-1:0] an,
    output logic              dp
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int k = 0; k < n; k++) r = r * 32'd10;
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    localparam logic [31:0]       OVF_LIM  = pow10(DIGITS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_n_q, ovf_n_d;
    logic [BCD_W-1:0]   disp_q;
    logic               ovf_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_n_d = ovf_n_q;
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = data;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_n_d = (32'(data) >= OVF_LIM);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Upper BCD bits fall off the top; ovf_n already flags that case.
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        bcd_q   <= bcd_d;
        cnt_q   <= cnt_d;
        ovf_n_q <= ovf_n_d;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else if (state_q == COMMIT) begin
            disp_q <= bcd_q;
            ovf_q  <= ovf_n_q;
        end
    end

    assign busy = (state_q != IDLE);
    assign ovf  = ovf_q;

    logic [SCAN_DIV-1:0]  presc_q;
    logic [BLINK_DIV-1:0] blink_q;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [6:0]           seg_q, seg_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic                 dp_q, dp_d;
    logic [3:0]           nib;
    logic                 dp_req, blink_req, blanked, lz, an_on;

    always_comb begin
        idx_d = idx_q;
        if (&presc_q) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    always_comb begin
        nib       = 4'd0;
        dp_req    = 1'b0;
        blink_req = 1'b0;
        blanked   = 1'b0;
        lz        = 1'b1;
        // Walk from the most significant digit so lz means "this and all higher nibbles are zero".
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lz = lz && (disp_q[4*k +: 4] == 4'd0);
            if (idx_q == IDX_W'(k)) begin
                nib       = disp_q[4*k +: 4];
                dp_req    = dp_in[k];
                blink_req = blink_en[k];
                blanked   = blank_lz && (k > 0) && lz && !ovf_q;
            end
        end
        an_on = !blanked && !(blink_req && blink_q[BLINK_DIV-1]);
        an_d  = ~(DIGITS'(an_on) << idx_q);
        seg_d = an_on ? (ovf_q ? 7'b0111111 : seg_decode(nib)) : 7'b1111111;
        dp_d  = an_on ? ~dp_req : 1'b1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_q <= '0;
            blink_q <= '0;
            idx_q   <= '0;
            seg_q   <= 7'b1000000;
            an_q    <= ~DIGITS'(1);
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
            blink_q <= blink_q + 1'b1;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign a_to_g = seg_q;
    assign an     = an_q;
    assign dp     = dp_q;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed 7-segment display driver for the board's common-anode LED digits. It converts a binary value to BCD with a sequential double-dabble engine and double-buffers the result, so the display never shows a partial conversion. It time-multiplexes `DIGITS` digits with per-digit decimal points, leading-zero blanking, per-digit blinking and overflow indication. It sits between game logic (scores, timers) and the board pins.

## Interface
- `DIGITS`, default 4: number of digits scanned, 1..8.
- `BIN_W`, default 16: width of the binary input, 1..27.
- `SCAN_DIV`, default 18: each digit is active for 2^SCAN_DIV clk cycles.
- `BLINK_DIV`, default 24: blink phase toggles every 2^(BLINK_DIV-1) clk cycles.

- `clk`  in  1  system clock.
- `clr`  in  1  reset, asynchronous, active-high.
- `data`  in  BIN_W  unsigned binary value; sampled on the accepted `load` edge.
- `load`  in  1  conversion request; honoured only when `busy`=0.
- `blank_lz`  in  1  1 = blank leading zeros.
- `dp_in`  in  DIGITS  decimal-point request per digit; bit 0 is the rightmost digit.
- `blink_en`  in  DIGITS  per-digit blink enable.
- `busy`  out  1  conversion in progress.
- `ovf`  out  1  latched value ≥ 10^DIGITS.
- `a_to_g`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  DIGITS  anodes, active-low, at most one low.
- `dp`  out  1  decimal point, active-low.

## Operation
- Conversion FSM has three states.
  - IDLE: on `load`=1, capture `data` into the shift register, clear the BCD accumulator (4*DIGITS bits), latch `ovf_n` = (`data` ≥ 10^DIGITS), then go to SHIFT.
  - SHIFT: runs for BIN_W cycles. Each cycle, every BCD nibble ≥ 5 gets +3, then {bcd, shift} shifts left by 1. The BCD accumulator's upper bits are truncated; `ovf` covers the lost digits.
  - COMMIT: lasts 1 cycle. Copy the BCD accumulator into the display register, copy `ovf_n` to `ovf`, then go to IDLE.
- `load` is ignored in SHIFT and COMMIT; no queuing. The display register holds the previous value throughout a conversion.
- Scan logic
  - SCAN_DIV-bit prescaler is free-running.
  - On prescaler wrap (all-ones→0), the scan index increments. It wraps from DIGITS-1 to 0, and non-power-of-2 DIGITS must never visit an index ≥ DIGITS.
  - BLINK_DIV-bit counter is free-running; blink phase is its MSB.
- Per-digit output for scan index i, with nibble d = display[4i+3:4i]:
  - If `ovf`: segments 0111111 (dash) on every digit. Blanking is ignored; blink still applies.
  - Otherwise decode d:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
    - any other value = 1111111.
  - Blanked when `blank_lz`=1, i>0, and nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked.
  - Anode i is driven low unless the digit is blanked, or `blink_en[i]`=1 with blink phase=1.
  - `dp` = ~`dp_in[i]` while anode i is low, else 1.
  - When the anode is off, `a_to_g` = 1111111.
- Reset state
  - FSM in IDLE; prescaler, blink counter and scan index all 0.
  - Display register 0; `busy`=0, `ovf`=0.
  - Outputs: `an` = all ones except bit 0 low, `a_to_g`=1000000, `dp`=1.
- `clr` mid-conversion aborts it: the display register clears and the result is discarded.

## Timing
- `load` sampled high at edge t (IDLE):
  - `busy`=1 after edge t.
  - Shifts occur on edges t+1..t+BIN_W.
  - Display register, `ovf` update and `busy`=0 occur on edge t+BIN_W+1.
  - Total latency is BIN_W+1 cycles; the next `load` is accepted at edge t+BIN_W+2.
- `a_to_g`, `an` and `dp` are registered. They reflect scan index, display register, `blank_lz`, `dp_in`, `blink_en` and blink phase with 1 cycle latency.
- A scan step changes the anode 1 cycle after the prescaler wrap edge. Each digit is active exactly 2^SCAN_DIV cycles. There is no overlap: at most one anode is low in any cycle.

## Test plan
Directed scenarios, with SCAN_DIV=2 and BLINK_DIV=5 unless stated.

1. Reset (DIGITS=4) → `an`=1110, `a_to_g`=1000000, `dp`=1, `busy`=0, `ovf`=0; after reset, each anode is low for exactly 4 cycles in order 0,1,2,3,0.
2. `load` with `data`=1234 → `busy` high for exactly 17 cycles; afterwards digit0=0011001 (4), digit1=0110000 (3), digit2=0100100 (2), digit3=1111001 (1); display unchanged while `busy`.
3. `data`=10000 (DIGITS=4) → `ovf`=1 and all four digits show 0111111; then `data`=9999 → `ovf`=0 and 0010000 on every digit.
4. `blank_lz`=1, `data`=7 → `an` bits 1..3 never low, digit0=1111000; `data`=0 → only digit0 lit with 1000000; `dp_in`=0100 with `data`=123 → `dp`=0 only while `an`=1011.
5. `load` pulsed again mid-SHIFT → ignored, second value never displayed; `clr` at SHIFT cycle 5 → `busy`=0 immediately, display shows 0; `blink_en`=0001 → anode 0 suppressed whenever blink phase=1.
6. DIGITS=6, BIN_W=20, `data`=999999 → scan wraps 5→0 (never 6 or 7), all digits 0010000, `ovf`=0; `data`=1000000 → `ovf`=1.
